// File: rtl/restoring_div_pkg.sv
// Shared types and defaults for the round-robin restoring divider.
package restoring_div_pkg;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_NUM_REQ = 2;

    // Quotient reported when the captured divisor is zero (all ones).
    localparam logic [DEF_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_div_arbiter_if.sv
// Requester/consumer bus of the shared divider.
interface restoring_div_arbiter_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_dividend;
    logic [NUM_REQ*WIDTH-1:0] req_divisor;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_quotient;
    logic [WIDTH-1:0]         rsp_remainder;
    logic                     rsp_div_by_zero;
    logic                     busy;

    // Producers/consumer side.
    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
               rsp_div_by_zero, busy
    );

    // Divider side.
    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
               rsp_div_by_zero, busy
    );
endinterface

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift {R,Q}, trial subtract, restore or commit.
module restoring_div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   trial;

    // R stays below 2^k after k steps, so the shifted remainder never overflows WIDTH bits.
    assign r_sh  = {r[WIDTH-2:0], q[WIDTH-1]};
    assign q_sh  = {q[WIDTH-2:0], 1'b0};
    assign trial = {1'b0, r_sh} - {1'b0, d};

    // Borrow means D does not fit: keep shifted R, quotient bit 0.
    always_comb begin
        r_next = r_sh;
        q_next = q_sh;
        if (!trial[WIDTH]) begin
            r_next    = trial[WIDTH-1:0];
            q_next[0] = 1'b1;
        end
    end
endmodule

// File: rtl/restoring_div_arbiter.sv
// Round-robin shared 16-bit restoring divider with id-tagged responses.
module restoring_div_arbiter
    import restoring_div_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    restoring_div_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   d_r;
    logic [CNT_W-1:0]   count;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    id_r;
    logic               dbz_r;
    logic               valid_r;
    logic               busy_r;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic               found;
    logic [WIDTH-1:0]   r_next;
    logic [WIDTH-1:0]   q_next;
    logic [WIDTH-1:0]   dividend_a [NUM_REQ];
    logic [WIDTH-1:0]   divisor_a  [NUM_REQ];
    logic [WIDTH-1:0]   sel_dividend;
    logic [WIDTH-1:0]   sel_divisor;

    // Split the flat operand buses into per-requester words.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
        assign dividend_a[i] = bus.req_dividend[i*WIDTH +: WIDTH];
        assign divisor_a[i]  = bus.req_divisor[i*WIDTH +: WIDTH];
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(last_grant) + 32'd1 + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign sel_dividend  = dividend_a[grant_idx];
    assign sel_divisor   = divisor_a[grant_idx];
    assign bus.req_ready = (state == ST_IDLE) ? grant : '0;

    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_r),
        .q      (q_r),
        .d      (d_r),
        .r_next (r_next),
        .q_next (q_next)
    );

    // Control FSM, operand capture, iteration and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            q_r        <= '0;
            r_r        <= '0;
            d_r        <= '0;
            count      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            id_r       <= '0;
            dbz_r      <= 1'b0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        last_grant <= grant_idx;
                        id_r       <= grant_idx;
                        count      <= '0;
                        busy_r     <= 1'b1;
                        d_r        <= sel_divisor;
                        if (sel_divisor == '0) begin
                            q_r     <= '1;
                            r_r     <= sel_dividend;
                            dbz_r   <= 1'b1;
                            valid_r <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            q_r     <= sel_dividend;
                            r_r     <= '0;
                            dbz_r   <= 1'b0;
                            state   <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    q_r   <= q_next;
                    r_r   <= r_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        valid_r <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid       = valid_r;
    assign bus.rsp_id          = id_r;
    assign bus.rsp_quotient    = q_r;
    assign bus.rsp_remainder   = r_r;
    assign bus.rsp_div_by_zero = dbz_r;
    assign bus.busy            = busy_r;
endmodule

// File: tb/tb_restoring_div_arbiter.sv
// Directed and scoreboarded checks for the shared restoring divider.
module tb_restoring_div_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    restoring_div_arbiter_if #(.WIDTH(16), .NUM_REQ(2), .ID_W(1)) bus ();

    restoring_div_arbiter #(.WIDTH(16), .NUM_REQ(2), .ID_W(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until rsp_valid, counting cycles from the current one (bounded).
    task automatic wait_rsp(input int start, output int n);
        n = start;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (bus.req_ready == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check("grant_timeout", 32'(n < 40), 32'd1);
    endtask

    // Single job from one requester, from IDLE through handshake.
    task automatic run_job(input int req, input logic [15:0] dvd, input logic [15:0] dvs,
                           input logic [15:0] eq, input logic [15:0] er,
                           input logic edbz, input int elat);
        int n;
        bus.req_dividend[req*16 +: 16] = dvd;
        bus.req_divisor[req*16 +: 16]  = dvs;
        bus.req_valid = 2'b00;
        bus.req_valid[req] = 1'b1;
        #1;
        check("grant", 32'(bus.req_ready), 32'(1 << req));
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(1, n);
        check("latency", 32'(n), 32'(elat));
        check("rsp_id", 32'(bus.rsp_id), 32'(req));
        check("quotient", 32'(bus.rsp_quotient), 32'(eq));
        check("remainder", 32'(bus.rsp_remainder), 32'(er));
        check("dbz", 32'(bus.rsp_div_by_zero), 32'(edbz));
        check("busy_done", 32'(bus.busy), 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] held_q;
        int          n;

        clk = 1'b0;
        rst = 1'b1;
        n_checks = 0;
        n_pass   = 0;
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = 1'b0;

        // Reset state.
        #12;
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_q", 32'(bus.rsp_quotient), 32'd0);
        check("rst_r", 32'(bus.rsp_remainder), 32'd0);
        check("rst_dbz", 32'(bus.rsp_div_by_zero), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_no_req", 32'(bus.req_ready), 32'd0);

        // Basic division and divide-by-zero.
        run_job(0, 16'hAD6D, 16'h3939, 16'h0003, 16'h01C2, 1'b0, 17);
        run_job(1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);

        // Both requesters hammering: alternate 0,1,0,1.
        bus.req_dividend = {16'd1000, 16'd100};
        bus.req_divisor  = {16'd33,   16'd7};
        bus.req_valid    = 2'b11;
        bus.rsp_ready    = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            wait_grant();
            check("rr_grant", 32'(bus.req_ready), (j % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            wait_rsp(1, n);
            check("rr_lat", 32'(n), 32'd17);
            check("rr_no_ready", 32'(bus.req_ready), 32'd0);
            check("rr_id", 32'(bus.rsp_id), 32'(j % 2));
            check("rr_q", 32'(bus.rsp_quotient), (j % 2 == 0) ? 32'd14 : 32'd30);
            check("rr_r", 32'(bus.rsp_remainder), (j % 2 == 0) ? 32'd2 : 32'd10);
            tick();
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check("rr_drain", 32'(bus.rsp_valid), 32'd0);

        // Edge operands.
        run_job(0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
        run_job(0, 16'h0005, 16'h0007, 16'h0000, 16'h0005, 1'b0, 17);
        run_job(1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17);

        // Consumer stalls: result held, no new grant.
        bus.req_dividend = {16'd50000, 16'd9};
        bus.req_divisor  = {16'd123,   16'd2};
        bus.req_valid    = 2'b10;
        #1;
        check("stall_grant", 32'(bus.req_ready), 32'd2);
        tick();
        bus.req_valid = 2'b11;
        wait_rsp(1, n);
        check("stall_lat", 32'(n), 32'd17);
        held_q = bus.rsp_quotient;
        check("stall_q0", 32'(held_q), 32'd406);
        for (int j = 0; j < 5; j++) begin
            tick();
            check("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_q", 32'(bus.rsp_quotient), 32'd406);
            check("stall_r", 32'(bus.rsp_remainder), 32'd62);
            check("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("stall_release", 32'(bus.rsp_valid), 32'd0);

        // Reset in the middle of a job, then pointer back to requester 0.
        bus.req_dividend = {16'd9999, 16'd200};
        bus.req_divisor  = {16'd7,    16'd9};
        bus.req_valid    = 2'b10;
        #1;
        check("mid_grant", 32'(bus.req_ready), 32'd2);
        tick();
        bus.req_valid = 2'b00;
        for (int j = 0; j < 7; j++) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_q", 32'(bus.rsp_quotient), 32'd0);
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (bus.rsp_valid) check("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        bus.req_valid = 2'b11;
        #1;
        check("rst_rr", 32'(bus.req_ready), 32'd1);
        run_job(0, 16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 17);

        // Scoreboard against reference / and %.
        for (int j = 0; j < 8; j++) begin
            a = 16'($urandom);
            b = 16'($urandom) >> j;
            if (j == 3) b = 16'd0;
            if (b == 16'd0) run_job(j % 2, a, b, 16'hFFFF, a, 1'b1, 1);
            else            run_job(j % 2, a, b, a / b, a % b, 1'b0, 17);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
